// File: rtl/crossing_request_scheduler.sv
// Crossing request scheduler: latches pedestrian/cyclist button presses,
// enforces a minimum traffic-green dwell, arbitrates round-robin between the
// two requesters and issues start to the light sequencer. If the sequencer
// never leaves idle after start, the block locks into a fault state that only
// reset clears. All outputs are decoded from registers (Moore).
module crossing_request_scheduler #(
    parameter int unsigned MIN_GREEN = 10,
    parameter int unsigned HOLD      = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_tick,
    input  logic i_ped_req,
    input  logic i_cyc_req,
    input  logic i_light_idle,
    output logic o_start,
    output logic o_ped_wait,
    output logic o_cyc_wait,
    output logic o_grant_ped,
    output logic o_grant_cyc,
    output logic o_fault
);

    localparam logic [CNT_W-1:0] L_MIN_GREEN = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] L_HOLD      = CNT_W'(HOLD);

    typedef enum logic [1:0] {
        StGreen,
        StStart,
        StCrossing,
        StFault
    } state_e;

    // State registers
    state_e           r_state;
    logic [CNT_W-1:0] r_green_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_sel_cyc;     // requester served by the current crossing
    logic             r_last_cyc;    // winner of the previous arbitration
    logic             r_ped_prev;
    logic             r_cyc_prev;
    logic             r_ped_pending;
    logic             r_cyc_pending;

    // Next-state and combinational helpers
    state_e           w_state_d;
    logic [CNT_W-1:0] w_green_cnt_d;
    logic [CNT_W-1:0] w_hold_cnt_d;
    logic [CNT_W:0]   w_hold_inc;
    logic             w_sel_cyc_d;
    logic             w_last_cyc_d;
    logic             w_enter_start;
    logic             w_arb_cyc;
    logic             w_ped_edge;
    logic             w_cyc_edge;
    logic             w_ped_pending_d;
    logic             w_cyc_pending_d;
    logic             w_serving;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        w_arb_cyc = r_cyc_pending & (~r_ped_pending | ~r_last_cyc);
    end

    // Press detection and pending flags; a fresh edge beats the clear on START entry
    always_comb begin
        w_ped_edge      = i_ped_req & ~r_ped_prev;
        w_cyc_edge      = i_cyc_req & ~r_cyc_prev;
        w_ped_pending_d = w_ped_edge | (r_ped_pending & ~(w_enter_start & ~w_arb_cyc));
        w_cyc_pending_d = w_cyc_edge | (r_cyc_pending & ~(w_enter_start & w_arb_cyc));
    end

    // Next-state logic for the scheduler FSM and its dwell/timeout counters
    always_comb begin
        w_state_d     = r_state;
        w_green_cnt_d = r_green_cnt;
        w_hold_cnt_d  = r_hold_cnt;
        w_sel_cyc_d   = r_sel_cyc;
        w_last_cyc_d  = r_last_cyc;
        w_enter_start = 1'b0;
        // One wider than the counter so the reach test never wraps
        w_hold_inc    = {1'b0, r_hold_cnt} + (CNT_W+1)'(1);

        unique case (r_state)
            StGreen: begin
                if ((r_green_cnt == L_MIN_GREEN) && (r_ped_pending || r_cyc_pending)) begin
                    w_state_d     = StStart;
                    w_hold_cnt_d  = '0;
                    w_sel_cyc_d   = w_arb_cyc;
                    w_last_cyc_d  = w_arb_cyc;
                    w_enter_start = 1'b1;
                end else if (i_tick && i_light_idle && (r_green_cnt < L_MIN_GREEN)) begin
                    w_green_cnt_d = r_green_cnt + CNT_W'(1);
                end
            end
            StStart: begin
                // Sequencer acknowledgement takes priority over the timeout
                if (!i_light_idle) begin
                    w_state_d = StCrossing;
                end else if (i_tick) begin
                    if (r_hold_cnt < L_HOLD) begin
                        w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
                    end
                    if (w_hold_inc >= {1'b0, L_HOLD}) begin
                        w_state_d = StFault;
                    end
                end
            end
            StCrossing: begin
                if (i_light_idle) begin
                    w_state_d     = StGreen;
                    w_green_cnt_d = '0;
                end
            end
            StFault: begin
                w_state_d = StFault;
            end
            default: begin
                w_state_d = StGreen;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StGreen;
            r_green_cnt   <= '0;
            r_hold_cnt    <= '0;
            r_sel_cyc     <= 1'b0;
            r_last_cyc    <= 1'b1;
            // History reset high so a button held through reset is not a press
            r_ped_prev    <= 1'b1;
            r_cyc_prev    <= 1'b1;
            r_ped_pending <= 1'b0;
            r_cyc_pending <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_green_cnt   <= w_green_cnt_d;
            r_hold_cnt    <= w_hold_cnt_d;
            r_sel_cyc     <= w_sel_cyc_d;
            r_last_cyc    <= w_last_cyc_d;
            r_ped_prev    <= i_ped_req;
            r_cyc_prev    <= i_cyc_req;
            r_ped_pending <= w_ped_pending_d;
            r_cyc_pending <= w_cyc_pending_d;
        end
    end

    // Moore outputs decoded from registered state
    always_comb begin
        w_serving   = (r_state == StStart) || (r_state == StCrossing);
        o_start     = (r_state == StStart);
        o_fault     = (r_state == StFault);
        o_grant_ped = w_serving & ~r_sel_cyc;
        o_grant_cyc = w_serving & r_sel_cyc;
        o_ped_wait  = r_ped_pending;
        o_cyc_wait  = r_cyc_pending;
    end

endmodule
